// File: rtl/jtkcpu_idxseq.sv
// jtkcpu_idxseq - indexed-addressing operand sequencer for the KCPU core.
// Fetches the postbyte and any 8/16-bit offset bytes from the instruction
// stream, forms the effective address from the selected index register and
// optionally follows a 16-bit indirect pointer. Reports EA and the updated PC
// to the main sequencer with a one-cycle done pulse.
// Build option: define JTKCPU_IDXIND_EN to build the indirect pointer fetch.
// Without it postbyte[4] does not select indirection and CALC always goes to DONE.
module jtkcpu_idxseq #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] pc_in,
  output logic [2:0]    idx_sel,
  input  logic [15:0]   idx_reg,
  input  logic [7:0]    a,
  input  logic [7:0]    b,
  output logic [AW-1:0] bus_addr,
  output logic          bus_rd,
  input  logic          bus_ok,
  input  logic [7:0]    bus_din,
  output logic [7:0]    postbyte,
  output logic [AW-1:0] ea,
  output logic [AW-1:0] pc_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PB,
    S_OFS_HI,
    S_OFS_LO,
    S_CALC,
    S_IND_HI,
    S_IND_LO,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [15:0]   ofs_data;
  logic [1:0]    pb_bytes;
  logic [15:0]   ofs;
  logic          use_idx;
  logic [15:0]   calc_ea;
`ifdef JTKCPU_IDXIND_EN
  logic          ind_sel;
  logic [7:0]    ind_hi;
`endif

  // Number of offset bytes that follow a postbyte, decoded from the bus byte
  // itself so the branch out of PB happens in the cycle the byte arrives.
  always_comb begin
    pb_bytes = 2'd0;
    if (!bus_din[7]) begin
      case (bus_din[3:0])
        4'b1000, 4'b1100:          pb_bytes = 2'd1;
        4'b1001, 4'b1101, 4'b1111: pb_bytes = 2'd2;
        default:                   pb_bytes = 2'd0;
      endcase
    end
  end

  // Offset selection and effective address from the latched postbyte.
  always_comb begin
    ofs     = '0;
    use_idx = 1'b1;
`ifdef JTKCPU_IDXIND_EN
    ind_sel = 1'b0;
`endif
    if (postbyte[7]) begin
      ofs = {{11{postbyte[4]}}, postbyte[4:0]};
    end else begin
`ifdef JTKCPU_IDXIND_EN
      ind_sel = postbyte[4];
`endif
      case (postbyte[3:0])
        4'b0000:          ofs = 16'h0001;
        4'b0001:          ofs = 16'h0002;
        4'b0010:          ofs = 16'hFFFF;
        4'b0011:          ofs = 16'hFFFE;
        4'b0100:          ofs = 16'h0000;
        4'b0101:          ofs = {{8{b[7]}}, b};
        4'b0110:          ofs = {{8{a[7]}}, a};
        4'b1000, 4'b1100: ofs = {{8{ofs_data[7]}}, ofs_data[7:0]};
        4'b1001, 4'b1101: ofs = ofs_data;
        4'b1011:          ofs = {a, b};
        4'b1111: begin
          ofs     = ofs_data;
          use_idx = 1'b0;
        end
        default:          ofs = 16'h0000;
      endcase
    end
    calc_ea = (use_idx ? idx_reg : 16'h0000) + ofs;
  end

  // Sequencer FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      ofs_data <= '0;
      idx_sel  <= '0;
      bus_addr <= '0;
      bus_rd   <= 1'b0;
      postbyte <= '0;
      ea       <= '0;
      pc_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef JTKCPU_IDXIND_EN
      ind_hi   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ptr      <= pc_in;
            bus_addr <= pc_in;
            bus_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_PB;
          end
        end

        S_PB: begin
          if (bus_ok) begin
            postbyte <= bus_din;
            idx_sel  <= {bus_din[1], bus_din[6:5]};
            ptr      <= ptr + AW'(1);
            bus_addr <= ptr + AW'(1);
            case (pb_bytes)
              2'd2:    state <= S_OFS_HI;
              2'd1:    state <= S_OFS_LO;
              default: begin
                bus_rd <= 1'b0;
                state  <= S_CALC;
              end
            endcase
          end
        end

        S_OFS_HI: begin
          if (bus_ok) begin
            ofs_data[15:8] <= bus_din;
            ptr            <= ptr + AW'(1);
            bus_addr       <= ptr + AW'(1);
            state          <= S_OFS_LO;
          end
        end

        S_OFS_LO: begin
          if (bus_ok) begin
            ofs_data[7:0] <= bus_din;
            ptr           <= ptr + AW'(1);
            bus_rd        <= 1'b0;
            state         <= S_CALC;
          end
        end

        S_CALC: begin
          ea     <= AW'(calc_ea);
          pc_out <= ptr;
`ifdef JTKCPU_IDXIND_EN
          if (ind_sel) begin
            bus_addr <= AW'(calc_ea);
            bus_rd   <= 1'b1;
            state    <= S_IND_HI;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
`else
          done  <= 1'b1;
          state <= S_DONE;
`endif
        end

`ifdef JTKCPU_IDXIND_EN
        S_IND_HI: begin
          if (bus_ok) begin
            ind_hi   <= bus_din;
            bus_addr <= bus_addr + AW'(1);
            state    <= S_IND_LO;
          end
        end

        S_IND_LO: begin
          if (bus_ok) begin
            ea     <= AW'({ind_hi, bus_din});
            bus_rd <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          bus_rd <= 1'b0;
          done   <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtkcpu_idxseq.sv
// Directed testbench for jtkcpu_idxseq with a byte-wide memory responder.
module tb_jtkcpu_idxseq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] pc_in;
  logic [2:0]  idx_sel;
  logic [15:0] idx_reg;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_ok;
  logic [7:0]  bus_din;
  logic [7:0]  postbyte;
  logic [15:0] ea;
  logic [15:0] pc_out;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:65535];
  int unsigned wait_n;
  int unsigned wcnt;
  logic [15:0] hold_addr;
  int          stab_err;
  int          total;
  int          bad;

  jtkcpu_idxseq #(.AW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pc_in    (pc_in),
    .idx_sel  (idx_sel),
    .idx_reg  (idx_reg),
    .a        (a),
    .b        (b),
    .bus_addr (bus_addr),
    .bus_rd   (bus_rd),
    .bus_ok   (bus_ok),
    .bus_din  (bus_din),
    .postbyte (postbyte),
    .ea       (ea),
    .pc_out   (pc_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: wait_n idle cycles before each accepted byte,
  // flags any address change while a read is waiting.
  always @(negedge clk) begin
    if (!rst_n || !bus_rd) begin
      bus_ok  = 1'b0;
      bus_din = 8'h5A;
      wcnt    = 0;
    end else begin
      if (wcnt > 0 && bus_addr !== hold_addr) stab_err++;
      hold_addr = bus_addr;
      if (wcnt >= wait_n) begin
        bus_ok  = 1'b1;
        bus_din = mem[bus_addr];
        wcnt    = 0;
      end else begin
        bus_ok  = 1'b0;
        bus_din = 8'h5A;
        wcnt++;
      end
    end
  end

  // Issue one start and wait for done; optional start pokes while busy / in DONE.
  task automatic run_seq(input logic [15:0] pc, input int unsigned waits,
                         input int poke, input bit poke_done,
                         output int cyc, output bit to);
    wait_n = waits;
    cyc    = 0;
    to     = 1'b1;
    pc_in  = pc;
    start  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      pc_in = 16'h0000;
      if (done) begin
        to = 1'b0;
        break;
      end
      if (cyc == poke) begin
        start = 1'b1;
        pc_in = 16'h7777;
      end
    end
    if (poke_done) begin
      start = 1'b1;
      pc_in = 16'h7777;
      @(negedge clk);
      start = 1'b0;
      pc_in = 16'h0000;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus_rd, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000", {bus_rd, busy, done});
    end
    total++;
    if ({bus_addr, ea, pc_out} !== 48'h0) begin
      bad++;
      $display("FAIL reset_addr got=%h exp=0", {bus_addr, ea, pc_out});
    end
    total++;
    if ({postbyte, idx_sel} !== 11'h0) begin
      bad++;
      $display("FAIL reset_pb got=%h exp=0", {postbyte, idx_sel});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_short5;
    int cyc;
    bit to;
    mem[16'h1000] = 8'h85;
    idx_reg = 16'h2000;
    run_seq(16'h1000, 0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 3) begin bad++; $display("FAIL short5_lat got=%0d to=%0b exp=3", cyc, to); end
    total++;
    if (ea !== 16'h2005) begin bad++; $display("FAIL short5_ea got=%h exp=2005", ea); end
    total++;
    if (pc_out !== 16'h1001) begin bad++; $display("FAIL short5_pc got=%h exp=1001", pc_out); end
    total++;
    if (postbyte !== 8'h85 || idx_sel !== 3'd0) begin
      bad++; $display("FAIL short5_pb got=%h/%0d exp=85/0", postbyte, idx_sel);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL short5_pulse got done=%b busy=%b exp=0/0", done, busy);
    end
    total++;
    if (ea !== 16'h2005) begin bad++; $display("FAIL short5_hold got=%h exp=2005", ea); end
  endtask

  task automatic test_ofs8;
    int cyc;
    bit to;
    mem[16'h2000] = 8'h08;
    mem[16'h2001] = 8'hF0;
    idx_reg = 16'h0010;
    run_seq(16'h2000, 0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 4) begin bad++; $display("FAIL ofs8_lat got=%0d to=%0b exp=4", cyc, to); end
    total++;
    if (ea !== 16'h0000) begin bad++; $display("FAIL ofs8_ea got=%h exp=0000", ea); end
    total++;
    if (pc_out !== 16'h2002) begin bad++; $display("FAIL ofs8_pc got=%h exp=2002", pc_out); end
    @(negedge clk);
  endtask

  task automatic test_ofs16_wait;
    int cyc;
    bit to;
    mem[16'h3000] = 8'h09;
    mem[16'h3001] = 8'h12;
    mem[16'h3002] = 8'h34;
    idx_reg  = 16'hF000;
    stab_err = 0;
    run_seq(16'h3000, 2, 2, 1'b0, cyc, to);
    total++;
    if (to || cyc != 11) begin bad++; $display("FAIL ofs16_lat got=%0d to=%0b exp=11", cyc, to); end
    total++;
    if (ea !== 16'h0234) begin bad++; $display("FAIL ofs16_ea got=%h exp=0234", ea); end
    total++;
    if (pc_out !== 16'h3003) begin bad++; $display("FAIL ofs16_pc got=%h exp=3003", pc_out); end
    total++;
    if (stab_err != 0) begin bad++; $display("FAIL ofs16_stable got=%0d exp=0", stab_err); end
    wait_n = 0;
    @(negedge clk);
  endtask

  task automatic test_indirect;
    int cyc;
    bit to;
    mem[16'h5000] = 8'h1F;
    mem[16'h5001] = 8'h40;
    mem[16'h5002] = 8'h00;
    mem[16'h4000] = 8'hBE;
    mem[16'h4001] = 8'hEF;
    idx_reg = 16'h1234;
    run_seq(16'h5000, 0, 0, 1'b0, cyc, to);
`ifdef JTKCPU_IDXIND_EN
    total++;
    if (to || cyc != 7) begin bad++; $display("FAIL ind_lat got=%0d to=%0b exp=7", cyc, to); end
    total++;
    if (ea !== 16'hBEEF) begin bad++; $display("FAIL ind_ea got=%h exp=beef", ea); end
`else
    total++;
    if (to || cyc != 5) begin bad++; $display("FAIL ind_lat got=%0d to=%0b exp=5", cyc, to); end
    total++;
    if (ea !== 16'h4000) begin bad++; $display("FAIL ind_ea got=%h exp=4000", ea); end
`endif
    total++;
    if (pc_out !== 16'h5003) begin bad++; $display("FAIL ind_pc got=%h exp=5003", pc_out); end
    @(negedge clk);
  endtask

  task automatic test_acc;
    int cyc;
    bit to;
    mem[16'h0400] = 8'h0B;
    a = 8'h01;
    b = 8'h80;
    idx_reg = 16'h0100;
    run_seq(16'h0400, 0, 0, 1'b0, cyc, to);
    total++;
    if (to || ea !== 16'h0280) begin bad++; $display("FAIL acc_ab got=%h to=%0b exp=0280", ea, to); end
    total++;
    if (idx_sel !== 3'd4 || pc_out !== 16'h0401) begin
      bad++; $display("FAIL acc_ab_sel got=%0d/%h exp=4/0401", idx_sel, pc_out);
    end
    @(negedge clk);
    mem[16'h0500] = 8'h06;
    a = 8'hFF;
    run_seq(16'h0500, 0, 0, 1'b0, cyc, to);
    total++;
    if (to || ea !== 16'h00FF) begin bad++; $display("FAIL acc_a got=%h to=%0b exp=00ff", ea, to); end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int cyc;
    bit to;
    mem[16'h0600] = 8'h01;
    idx_reg = 16'hFFFF;
    run_seq(16'h0600, 0, 0, 1'b0, cyc, to);
    total++;
    if (to || ea !== 16'h0001) begin bad++; $display("FAIL wrap_up got=%h to=%0b exp=0001", ea, to); end
    @(negedge clk);
    mem[16'h0700] = 8'hFF;
    idx_reg = 16'h0000;
    run_seq(16'h0700, 0, 0, 1'b0, cyc, to);
    total++;
    if (to || ea !== 16'hFFFF) begin bad++; $display("FAIL wrap_dn got=%h to=%0b exp=ffff", ea, to); end
    total++;
    if (idx_sel !== 3'd7) begin bad++; $display("FAIL wrap_sel got=%0d exp=7", idx_sel); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit to;
    mem[16'h0800] = 8'h85;
    mem[16'h0900] = 8'h00;
    idx_reg = 16'h0200;
    run_seq(16'h0800, 0, 0, 1'b1, cyc, to);
    total++;
    if (to || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_done_start got busy=%b done=%b to=%0b exp=0/0", busy, done, to);
    end
    run_seq(16'h0900, 0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 3 || ea !== 16'h0201 || pc_out !== 16'h0901) begin
      bad++; $display("FAIL b2b_second got=%0d/%h/%h exp=3/0201/0901", cyc, ea, pc_out);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    int cyc;
    bit to;
    bit seen_done;
    mem[16'h6000] = 8'h68;
    mem[16'h6001] = 8'h05;
    idx_reg = 16'h1000;
    wait_n  = 3;
    pc_in   = 16'h6000;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (bus_rd !== 1'b1 || bus_addr !== 16'h6001 || idx_sel !== 3'd3) begin
      bad++; $display("FAIL rmid_ofslo got rd=%b addr=%h sel=%0d exp=1/6001/3", bus_rd, bus_addr, idx_sel);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus_rd, busy, done, bus_addr, postbyte, idx_sel} !== 30'h0) begin
      bad++; $display("FAIL rmid_outs got=%h exp=0", {bus_rd, busy, done, bus_addr, postbyte, idx_sel});
    end
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (i == 1) rst_n = 1'b1;
    end
    total++;
    if (seen_done) begin bad++; $display("FAIL rmid_nodone got=1 exp=0"); end
    run_seq(16'h6000, 0, 0, 1'b0, cyc, to);
    total++;
    if (to || cyc != 4 || ea !== 16'h1005 || pc_out !== 16'h6002) begin
      bad++; $display("FAIL rmid_restart got=%0d/%h/%h exp=4/1005/6002", cyc, ea, pc_out);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    stab_err = 0;
    wait_n   = 0;
    wcnt     = 0;
    start    = 1'b0;
    pc_in    = 16'h0000;
    idx_reg  = 16'h0000;
    a        = 8'h00;
    b        = 8'h00;
    bus_ok   = 1'b0;
    bus_din  = 8'h00;
    rst_n    = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset;
    test_short5;
    test_ofs8;
    test_ofs16_wait;
    test_indirect;
    test_acc;
    test_wrap;
    test_back_to_back;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtkcpu_idxseq.md
Name: jtkcpu_idxseq

Overview:
- Indexed-addressing operand sequencer for the KCPU core. It is the bus-side counterpart of the index offset calculator.
- Fetches the postbyte and any 8/16-bit offset bytes from the instruction stream, then forms the effective address (EA).
- Optionally fetches a 16-bit indirect pointer.
- Returns the EA and the updated PC to the main sequencer with a done pulse.
- Sits between the main instruction sequencer, the register file and the memory bus arbiter.

Parameters:
- AW, 16, address width. All address ports, PC and EA are AW bits.

Ports:
- clk      in   1   system clock
- rst_n    in   1   asynchronous reset, active-low
- start    in   1   one-cycle request; pc_in valid on the same cycle
- pc_in    in   AW  address of the postbyte
- idx_sel  out  3   register select {postbyte[1], postbyte[6:5]}; valid from the cycle after the postbyte is accepted until done
- idx_reg  in   16  selected index register; combinational from the register file, sampled in CALC
- a        in   8   accumulator A
- b        in   8   accumulator B
- bus_addr out  AW  read address
- bus_rd   out  1   read request
- bus_ok   in   1   byte accepted; bus_din valid in the same cycle
- bus_din  in   8   read data
- postbyte out  8   latched postbyte
- ea       out  AW  effective address
- pc_out   out  AW  pc_in + bytes consumed (postbyte + offset bytes)
- busy     out  1   high while not IDLE
- done     out  1   one-cycle pulse; ea and pc_out valid and held until the next start

Behaviour:
- Reset values: every output 0; FSM in IDLE.
- rst_n low mid-sequence aborts immediately to IDLE. No done is issued.
- States: IDLE, PB, OFS_HI, OFS_LO, CALC, IND_HI, IND_LO, DONE.

State transitions:
- IDLE: start -> PB; capture pc_in into the internal pointer. start while busy is ignored.
- PB: bus_rd=1, bus_addr=ptr. On bus_ok: latch postbyte, ptr+=1, then branch:
  - mode 2-byte -> OFS_HI
  - mode 1-byte -> OFS_LO
  - otherwise -> CALC
- OFS_HI / OFS_LO: read the offset big-endian, ptr+=1 per accepted byte. OFS_HI -> OFS_LO. OFS_LO -> CALC.
- Any read state holds bus_rd and bus_addr stable until bus_ok. There is no timeout.

Postbyte decode:
- postbyte[7]=1: offset = sign-extended postbyte[4:0]. Never indirect, no extra bytes.
- postbyte[7]=0: indirect = postbyte[4]; offset from postbyte[3:0]:
  - 0000:+1
  - 0001:+2
  - 0010:-1
  - 0011:-2
  - 0100:0
  - 0101:sext(B)
  - 0110:sext(A)
  - 1000/1100: sext(8-bit data), 1 extra byte
  - 1001/1101: 16-bit data, 2 extra bytes
  - 1011: {A,B}
  - 1111: extended; EA = 16-bit data, idx_reg ignored, 2 extra bytes
  - others: 0

Address calculation and completion:
- CALC: EA = idx_reg + offset, modulo 2^16; wrap is silent (FFFF+2=0001). pc_out = ptr. If indirect -> IND_HI, else -> DONE.
- IND_HI / IND_LO: read from EA then EA+1 (wrapping). The final EA is the {hi,lo} pair read. Indirect reads do not advance pc_out.
- DONE: done=1 for one cycle -> IDLE. start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.

Latency with zero wait states, start cycle to done:
- 1-byte direct: 3 cycles.
- Add +1 per offset byte and +2 for indirect.

Optional Feature:
- Macro: JTKCPU_IDXIND_EN.
- Defined: indirect fetch as above.
- Undefined: IND_HI/IND_LO are not built. postbyte[4] is ignored for indirection and the FSM always goes CALC -> DONE.

Test Plan:
- Postbyte 0x85 at pc_in=0x1000, idx_reg=0x2000, no waits -> ea=0x2005, pc_out=0x1001, done 3 cycles after start.
- Postbyte 0x08, data 0xF0, idx_reg=0x0010 -> ea=0x0000, pc_out=pc_in+2.
- Postbyte 0x09, data 0x12,0x34, idx_reg=0xF000, with 2 wait cycles on each read -> ea=0x0234; bus_addr stable during waits.
- Postbyte 0x1F, data 0x40,0x00, memory[0x4000]=0xBE, [0x4001]=0xEF -> ea=0xBEEF, pc_out=pc_in+3. Without the macro -> ea=0x4000.
- Postbyte 0x0B, A=0x01, B=0x80, idx_reg=0x0100 -> ea=0x0280. Postbyte 0x06 with A=0xFF -> ea=idx_reg-1.
- rst_n pulsed low while in OFS_LO -> all outputs 0, no done. The next start completes normally.
